// File: rtl/phase_sequencer.sv
// Phase sequencer for a two-road intersection with a pedestrian crossing over
// the main road. Each phase is timed by counting one-second enable pulses from
// an external divider. The divider is restarted on every phase change, so
// each phase begins on a full second. Side-road and pedestrian requests are
// latched until the phase that serves them is entered. Lamp outputs are
// decoded from the state register only.
module phase_sequencer #(
    parameter int unsigned INIT_TIME       = 2,
    parameter int unsigned MAIN_GREEN_MIN  = 10,
    parameter int unsigned YELLOW_TIME     = 3,
    parameter int unsigned ALL_RED_TIME    = 1,
    parameter int unsigned SIDE_GREEN_TIME = 6,
    parameter int unsigned WALK_TIME       = 5
) (
    input  logic       clk,
    input  logic       sequencer_reset_n,
    input  logic       one_sec_tick,
    input  logic       side_sensor,
    input  logic       ped_button,
    output logic       tick_reset,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    // State codes double as the debug phase code.
    typedef enum logic [2:0] {
        ST_INIT        = 3'd0,
        ST_MAIN_GREEN  = 3'd1,
        ST_MAIN_YELLOW = 3'd2,
        ST_ALL_RED_1   = 3'd3,
        ST_PED_WALK    = 3'd4,
        ST_SIDE_GREEN  = 3'd5,
        ST_SIDE_YELLOW = 3'd6,
        ST_ALL_RED_2   = 3'd7
    } state_t;

    // Lamp encodings {red, yellow, green}.
    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Last counter value of each timed phase; a phase of D seconds ends on
    // the tick seen while the counter holds D-1. All times are 1..63.
    localparam logic [5:0] INIT_LAST   = 6'(INIT_TIME - 1);
    localparam logic [5:0] MG_LAST     = 6'(MAIN_GREEN_MIN - 1);
    localparam logic [5:0] YELLOW_LAST = 6'(YELLOW_TIME - 1);
    localparam logic [5:0] ALLRED_LAST = 6'(ALL_RED_TIME - 1);
    localparam logic [5:0] SG_LAST     = 6'(SIDE_GREEN_TIME - 1);
    localparam logic [5:0] WALK_LAST   = 6'(WALK_TIME - 1);

    state_t     state_q, state_d;
    logic [5:0] sec_cnt_q, sec_cnt_d;
    logic       min_done_q, min_done_d;
    logic       ped_pending_q, ped_pending_d;
    logic       side_pending_q, side_pending_d;
    logic       tick_reset_q, tick_reset_d;

    logic       tick_ok;
    logic       ped_req;
    logic       side_req;
    logic [5:0] phase_last;
    logic       phase_done;
    logic       state_change;

    // Qualify the tick and merge latched requests with same-cycle inputs.
    // A tick in the first cycle of a phase belongs to the old divider count,
    // so it is dropped to keep every phase a full number of seconds.
    always_comb begin
        tick_ok  = one_sec_tick & ~tick_reset_q;
        ped_req  = ped_pending_q | ped_button;
        side_req = side_pending_q | side_sensor;
    end

    // Select the duration of the current phase and detect its final tick.
    always_comb begin
        phase_last = INIT_LAST;
        unique case (state_q)
            ST_INIT:        phase_last = INIT_LAST;
            ST_MAIN_GREEN:  phase_last = MG_LAST;
            ST_MAIN_YELLOW: phase_last = YELLOW_LAST;
            ST_ALL_RED_1:   phase_last = ALLRED_LAST;
            ST_PED_WALK:    phase_last = WALK_LAST;
            ST_SIDE_GREEN:  phase_last = SG_LAST;
            ST_SIDE_YELLOW: phase_last = YELLOW_LAST;
            ST_ALL_RED_2:   phase_last = ALLRED_LAST;
        endcase
        phase_done = tick_ok && (sec_cnt_q == phase_last);
    end

    // Next-state logic for the phase FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_INIT: begin
                if (phase_done) state_d = ST_MAIN_GREEN;
            end
            ST_MAIN_GREEN: begin
                // Main green is held until the minimum has elapsed and
                // somebody is actually waiting; with no demand it stays.
                if ((min_done_q || phase_done) && (ped_req || side_req)) begin
                    state_d = ST_MAIN_YELLOW;
                end
            end
            ST_MAIN_YELLOW: begin
                if (phase_done) state_d = ST_ALL_RED_1;
            end
            ST_ALL_RED_1: begin
                if (phase_done) begin
                    if (ped_req)       state_d = ST_PED_WALK;
                    else if (side_req) state_d = ST_SIDE_GREEN;
                    else               state_d = ST_MAIN_GREEN;
                end
            end
            ST_PED_WALK: begin
                if (phase_done) begin
                    if (side_req) state_d = ST_SIDE_GREEN;
                    else          state_d = ST_ALL_RED_2;
                end
            end
            ST_SIDE_GREEN: begin
                if (phase_done) state_d = ST_SIDE_YELLOW;
            end
            ST_SIDE_YELLOW: begin
                if (phase_done) state_d = ST_ALL_RED_2;
            end
            ST_ALL_RED_2: begin
                if (phase_done) state_d = ST_MAIN_GREEN;
            end
        endcase
    end

    // Counter, minimum-green flag, divider restart and request latches.
    always_comb begin
        state_change = (state_d != state_q);

        sec_cnt_d = sec_cnt_q;
        if (state_change) begin
            sec_cnt_d = '0;
        end else if (tick_ok) begin
            // In main green the counter saturates at the minimum so that an
            // arbitrarily long green never wraps the 6-bit count.
            if (!((state_q == ST_MAIN_GREEN) && (sec_cnt_q == MG_LAST))) begin
                sec_cnt_d = sec_cnt_q + 6'd1;
            end
        end

        min_done_d = min_done_q;
        if (state_change) begin
            min_done_d = 1'b0;
        end else if ((state_q == ST_MAIN_GREEN) && phase_done) begin
            min_done_d = 1'b1;
        end

        // The divider is held in reset for the first cycle of every phase.
        tick_reset_d = state_change;

        // A new request in the same cycle as the serving phase's entry is
        // kept, so no press is ever lost.
        ped_pending_d  = ped_button |
                         (ped_pending_q & ~(state_change && (state_d == ST_PED_WALK)));
        side_pending_d = side_sensor |
                         (side_pending_q & ~(state_change && (state_d == ST_SIDE_GREEN)));
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!sequencer_reset_n) begin
            state_q        <= ST_INIT;
            sec_cnt_q      <= '0;
            min_done_q     <= 1'b0;
            ped_pending_q  <= 1'b0;
            side_pending_q <= 1'b0;
            tick_reset_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            sec_cnt_q      <= sec_cnt_d;
            min_done_q     <= min_done_d;
            ped_pending_q  <= ped_pending_d;
            side_pending_q <= side_pending_d;
            tick_reset_q   <= tick_reset_d;
        end
    end

    // Lamp decode from the registered state only.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        unique case (state_q)
            ST_MAIN_GREEN:  main_light = LAMP_GREEN;
            ST_MAIN_YELLOW: main_light = LAMP_YELLOW;
            ST_SIDE_GREEN:  side_light = LAMP_GREEN;
            ST_SIDE_YELLOW: side_light = LAMP_YELLOW;
            ST_PED_WALK:    walk       = 1'b1;
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    assign phase      = state_q;
    assign tick_reset = tick_reset_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: reset values, phase durations in ticks,
// request latching, ignored tick in the restart cycle, mid-phase reset, and a
// per-cycle safety/one-hot check on the lamps.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       sequencer_reset_n;
    logic       one_sec_tick;
    logic       side_sensor;
    logic       ped_button;
    logic       tick_reset;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic [2:0] phase;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic        inv_en   = 1'b0;
    logic        tr_seen  = 1'b0;

    phase_sequencer dut (
        .clk               (clk),
        .sequencer_reset_n (sequencer_reset_n),
        .one_sec_tick      (one_sec_tick),
        .side_sensor       (side_sensor),
        .ped_button        (ped_button),
        .tick_reset        (tick_reset),
        .main_light        (main_light),
        .side_light        (side_light),
        .walk              (walk),
        .phase             (phase)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_main(input logic [2:0] p);
        case (p)
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input logic [2:0] p);
        case (p)
            3'd5:    return 3'b001;
            3'd6:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic safe_ok(input logic [2:0] m, input logic [2:0] s, input logic w);
        logic mg;
        logic sg;
        mg = m[0] | m[1];
        sg = s[0] | s[1];
        return $onehot(m) && $onehot(s) && !(mg && sg) && !(w && (mg || sg));
    endfunction

    // Safety invariant and one-hot lamps, every cycle once out of time zero.
    always @(negedge clk) begin
        if (inv_en) begin
            check("safety", 32'(safe_ok(main_light, side_light, walk)), 32'd1);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One tick cycle (optionally with request inputs on the same cycle),
    // then seven quiet cycles. tr_seen captures tick_reset right after the
    // tick's edge, i.e. whether that tick started a new phase.
    task automatic tick_req(input logic ped, input logic side);
        one_sec_tick = 1'b1;
        ped_button   = ped;
        side_sensor  = side;
        cyc(1);
        tr_seen      = tick_reset;
        one_sec_tick = 1'b0;
        ped_button   = 1'b0;
        side_sensor  = 1'b0;
        cyc(7);
    endtask

    task automatic tick();
        tick_req(1'b0, 1'b0);
    endtask

    task automatic pulse(input logic ped, input logic side);
        ped_button  = ped;
        side_sensor = side;
        cyc(1);
        ped_button  = 1'b0;
        side_sensor = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [2:0] p);
        check({tag, ".phase"}, 32'(phase), 32'(p));
        check({tag, ".main"},  32'(main_light), 32'(exp_main(p)));
        check({tag, ".side"},  32'(side_light), 32'(exp_side(p)));
        check({tag, ".walk"},  32'(walk), 32'(p == 3'd4));
    endtask

    // Phase p must last exactly n ticks; only the last one restarts the divider.
    task automatic hold_phase(input string tag, input logic [2:0] p, input int n);
        for (int i = 0; i < n; i++) begin
            check_state(tag, p);
            tick();
            check({tag, ".tr"}, 32'(tr_seen), 32'(i == n - 1));
        end
    endtask

    task automatic restart();
        sequencer_reset_n = 1'b0;
        cyc(1);
        sequencer_reset_n = 1'b1;
        cyc(1);
        hold_phase("rst.init", 3'd0, 2);
        check_state("rst.mg", 3'd1);
    endtask

    initial begin
        sequencer_reset_n = 1'b0;
        one_sec_tick      = 1'b0;
        side_sensor       = 1'b0;
        ped_button        = 1'b0;

        // Reset held for 3 cycles.
        cyc(3);
        inv_en = 1'b1;
        check_state("reset", 3'd0);
        check("reset.tick_reset", 32'(tick_reset), 32'd1);
        check("reset.cnt",  32'(dut.sec_cnt_q), 32'd0);
        check("reset.ped",  32'(dut.ped_pending_q), 32'd0);
        check("reset.side", 32'(dut.side_pending_q), 32'd0);
        check("reset.min",  32'(dut.min_done_q), 32'd0);

        // Release: INIT for 2 ticks, then main green held with no demand.
        sequencer_reset_n = 1'b1;
        cyc(1);
        check("idle.tick_reset", 32'(tick_reset), 32'd0);
        hold_phase("init", 3'd0, 2);
        check_state("mg", 3'd1);
        check("mg.tick_reset_low", 32'(tick_reset), 32'd0);
        for (int i = 0; i < 50; i++) begin
            tick();
            check("mg.stay", 32'(phase), 32'd1);
        end
        check("mg.min_done", 32'(dut.min_done_q), 32'd1);

        // Side request at tick 3: exit on the 10th tick, side cycle follows.
        restart();
        for (int i = 0; i < 3; i++) tick();
        pulse(1'b0, 1'b1);
        check("s.side_latched", 32'(dut.side_pending_q), 32'd1);
        hold_phase("s.mg", 3'd1, 7);
        hold_phase("s.my", 3'd2, 3);
        hold_phase("s.ar1", 3'd3, 1);
        check("s.side_cleared", 32'(dut.side_pending_q), 32'd0);
        hold_phase("s.sg", 3'd5, 6);
        hold_phase("s.sy", 3'd6, 3);
        hold_phase("s.ar2", 3'd7, 1);
        check_state("s.back", 3'd1);

        // Both requests: walk then side green.
        pulse(1'b1, 1'b1);
        hold_phase("b.mg", 3'd1, 10);
        hold_phase("b.my", 3'd2, 3);
        hold_phase("b.ar1", 3'd3, 1);
        check("b.ped_cleared", 32'(dut.ped_pending_q), 32'd0);
        hold_phase("b.walk", 3'd4, 5);
        hold_phase("b.sg", 3'd5, 6);
        hold_phase("b.sy", 3'd6, 3);
        hold_phase("b.ar2", 3'd7, 1);
        check_state("b.back", 3'd1);
        check("b.ped_end",  32'(dut.ped_pending_q), 32'd0);
        check("b.side_end", 32'(dut.side_pending_q), 32'd0);

        // Pedestrian only, pressed again on the edge that enters the walk.
        pulse(1'b1, 1'b0);
        hold_phase("p.mg", 3'd1, 10);
        hold_phase("p.my", 3'd2, 3);
        check_state("p.ar1", 3'd3);
        tick_req(1'b1, 1'b0);
        check("p.walk_entry", 32'(phase), 32'd4);
        check("p.ped_kept", 32'(dut.ped_pending_q), 32'd1);
        hold_phase("p.walk", 3'd4, 5);
        hold_phase("p.ar2", 3'd7, 1);
        check_state("p.back", 3'd1);
        check("p.ped_pending", 32'(dut.ped_pending_q), 32'd1);
        hold_phase("p2.mg", 3'd1, 10);
        hold_phase("p2.my", 3'd2, 3);
        hold_phase("p2.ar1", 3'd3, 1);
        hold_phase("p2.walk", 3'd4, 5);
        hold_phase("p2.ar2", 3'd7, 1);
        check_state("p2.back", 3'd1);
        check("p2.ped_end", 32'(dut.ped_pending_q), 32'd0);

        // Exit off a tick; a tick in the restart cycle must not count.
        for (int i = 0; i < 10; i++) tick();
        check("i.mg", 32'(phase), 32'd1);
        check("i.min_done", 32'(dut.min_done_q), 32'd1);
        pulse(1'b0, 1'b1);
        check("i.my_entry", 32'(phase), 32'd2);
        check("i.tick_reset", 32'(tick_reset), 32'd1);
        tick();
        check("i.cnt_ignored", 32'(dut.sec_cnt_q), 32'd0);
        hold_phase("i.my", 3'd2, 3);
        hold_phase("i.ar1", 3'd3, 1);
        check_state("i.sg", 3'd5);

        // Reset for one cycle in the middle of side green.
        tick();
        pulse(1'b1, 1'b1);
        check("r.ped_set",  32'(dut.ped_pending_q), 32'd1);
        check("r.side_set", 32'(dut.side_pending_q), 32'd1);
        tick();
        check("r.sg", 32'(phase), 32'd5);
        sequencer_reset_n = 1'b0;
        cyc(1);
        sequencer_reset_n = 1'b1;
        check_state("r.reset", 3'd0);
        check("r.tick_reset", 32'(tick_reset), 32'd1);
        check("r.ped",  32'(dut.ped_pending_q), 32'd0);
        check("r.side", 32'(dut.side_pending_q), 32'd0);
        check("r.min",  32'(dut.min_done_q), 32'd0);
        check("r.cnt",  32'(dut.sec_cnt_q), 32'd0);
        cyc(1);
        hold_phase("r.init", 3'd0, 2);
        check_state("r.mg", 3'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
